// File: rtl/nn_pkg.sv
// Shared constants, state type and byte-selection helpers for the NN output serializer.
// Defining NN_OUT_CHECKSUM_EN appends an XOR checksum byte after neuron0 in every result set.
package nn_pkg;

   localparam int DATA_W      = 8;
   localparam int NUM_NEURONS = 4;
   localparam int SET_W       = NUM_NEURONS * DATA_W;

`ifdef NN_OUT_CHECKSUM_EN
   localparam int BYTES_PER_SET = NUM_NEURONS + 1;
`else
   localparam int BYTES_PER_SET = NUM_NEURONS;
`endif

   localparam int CNT_W = $clog2(BYTES_PER_SET);

   typedef enum logic {
      IDLE,
      STREAM
   } ser_state_e;

   // A result set is packed {neuron3, neuron2, neuron1, neuron0}.
   typedef logic [SET_W-1:0] result_set_t;

   // Byte k of the transmit order: neuron3 first, then the optional checksum last.
   function automatic logic [DATA_W-1:0] set_byte(input result_set_t s, input int k);
      logic [DATA_W-1:0] b;
      b = '0;
      if (k < NUM_NEURONS) begin
         b = s[(NUM_NEURONS-1-k)*DATA_W +: DATA_W];
      end
`ifdef NN_OUT_CHECKSUM_EN
      else begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            b = b ^ s[i*DATA_W +: DATA_W];
         end
      end
`endif
      return b;
   endfunction

   function automatic logic [1:0] byte_index(input int k);
      return (k < NUM_NEURONS) ? 2'(NUM_NEURONS - 1 - k) : 2'd0;
   endfunction

endpackage

// File: rtl/nn_output_serializer_if.sv
// Bundles neuron inputs, control strobes and the byte stream of the output serializer.
// The master modport is the serializer's view; the slave modport is the layer FSM / host side.
interface nn_output_serializer_if;
   import nn_pkg::*;

   logic              capture;
   logic [DATA_W-1:0] neuron0_output;
   logic [DATA_W-1:0] neuron1_output;
   logic [DATA_W-1:0] neuron2_output;
   logic [DATA_W-1:0] neuron3_output;
   logic              clr_ovf;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [1:0]        out_index;
   logic              full;
   logic              overflow;

   modport master (
      input  capture, neuron0_output, neuron1_output, neuron2_output, neuron3_output,
      input  clr_ovf, out_ready,
      output out_data, out_valid, out_last, out_index, full, overflow
   );

   modport slave (
      output capture, neuron0_output, neuron1_output, neuron2_output, neuron3_output,
      output clr_ovf, out_ready,
      input  out_data, out_valid, out_last, out_index, full, overflow
   );

endinterface

// File: rtl/nn_result_fifo.sv
// BANKS-deep buffer of captured result sets with head and next-head read ports.
// A pop while full frees a slot in time for the same cycle's push to be accepted.
module nn_result_fifo
   import nn_pkg::*;
#(
   parameter int BANKS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  result_set_t push_data_i,
   input  logic        pop_i,
   output result_set_t head_o,
   output result_set_t next_o,
   output logic        full_o,
   output logic        empty_o,
   output logic        multi_o
);

   localparam int PTR_W = $clog2(BANKS);
   localparam int OCC_W = $clog2(BANKS + 1);

   result_set_t      mem_q [BANKS];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] rptr_nxt;
   logic [OCC_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o   = (count_q == OCC_W'(BANKS));
   assign empty_o  = (count_q == '0);
   assign multi_o  = (count_q > OCC_W'(1));
   assign do_pop   = pop_i & ~empty_o;
   assign do_push  = push_i & (~full_o | do_pop);
   assign rptr_nxt = rptr_q + 1'b1;
   assign head_o   = mem_q[rptr_q];
   assign next_o   = mem_q[rptr_nxt];

   // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q marks which banks hold live data, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data_i;
   end

endmodule

// File: rtl/nn_output_serializer.sv
// Captures the four final-layer neuron outputs and streams each set out one byte per transfer.
// NN_OUT_CHECKSUM_EN adds a fifth XOR checksum byte carrying out_last.
module nn_output_serializer
   import nn_pkg::*;
#(
   parameter int BANKS = 2
) (
   input logic                   clk,
   input logic                   rstn,
   nn_output_serializer_if.master bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_SET - 1);

   ser_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic [1:0]        out_index_q;
   logic              overflow_q, overflow_d;

   result_set_t       head_set, next_set;
   logic              fifo_full, fifo_empty, fifo_multi;
   logic              xfer, pop, drop;

   assign xfer = out_valid_q & bus.out_ready;
   assign pop  = xfer & out_last_q;
   assign drop = bus.capture & fifo_full & ~pop;

   nn_result_fifo #(.BANKS(BANKS)) u_fifo (
      .clk         (clk),
      .rst         (rstn),
      .push_i      (bus.capture),
      .push_data_i ({bus.neuron3_output, bus.neuron2_output,
                     bus.neuron1_output, bus.neuron0_output}),
      .pop_i       (pop),
      .head_o      (head_set),
      .next_o      (next_set),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .multi_o     (fifo_multi)
   );

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_index_q <= 2'd3;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q     <= STREAM;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= set_byte(head_set, 0);
                  out_index_q <= byte_index(0);
                  out_last_q  <= 1'b0;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (out_last_q) begin
                     cnt_q <= '0;
                     // Head is being freed; a second occupied bank streams on without a bubble.
                     if (fifo_multi) begin
                        out_data_q  <= set_byte(next_set, 0);
                        out_index_q <= byte_index(0);
                        out_last_q  <= 1'b0;
                     end else begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q       <= cnt_q + 1'b1;
                     out_data_q  <= set_byte(head_set, int'(cnt_q) + 1);
                     out_index_q <= byte_index(int'(cnt_q) + 1);
                     out_last_q  <= ((cnt_q + 1'b1) == LAST_CNT);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (bus.clr_ovf) overflow_d = 1'b0;
      // A drop in the same cycle as a clear must stay visible.
      if (drop)        overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) overflow_q <= 1'b0;
      else      overflow_q <= overflow_d;
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_index = out_index_q;
   assign bus.full      = fifo_full;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nn_output_serializer.sv
// Self-checking bench for nn_output_serializer: a set-level queue model predicts the byte stream,
// occupancy, full and sticky overflow; randomized traffic plus directed boundary scenarios.
module tb_nn_output_serializer;

   localparam int BANKS = 2;
   localparam int DW    = 8;
`ifdef NN_OUT_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   typedef logic [10:0] rec_t;  // {last, index[1:0], data[7:0]}

   logic clk = 1'b0;
   logic rstn;

   nn_output_serializer_if bus ();

   nn_output_serializer #(.BANKS(BANKS)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   rec_t exp_q[$];
   rec_t got_q[$];
   int   occ;
   int   n_xfer;
   bit   m_ovf;

   task automatic model_reset();
      exp_q.delete();
      got_q.delete();
      occ    = 0;
      n_xfer = 0;
      m_ovf  = 0;
   endtask

   task automatic model_accept(input logic [DW-1:0] n0, n1, n2, n3);
      logic [DW-1:0] b[4];
      logic [DW-1:0] x;
      b = '{n3, n2, n1, n0};
      x = '0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({(NB == 4) && (i == 3), 2'(3 - i), b[i]});
         x ^= b[i];
      end
      if (NB == 5) exp_q.push_back({1'b1, 2'd0, x});
      occ++;
   endtask

   task automatic load(input logic [DW-1:0] n0, n1, n2, n3);
      bus.neuron0_output = n0;
      bus.neuron1_output = n1;
      bus.neuron2_output = n2;
      bus.neuron3_output = n3;
   endtask

   task automatic load_random();
      load(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
   endtask

   // Advance one clock: apply the set-level rules to this cycle's inputs, record any transfer.
   task automatic cycle();
      bit xf, done_set, dropped;
      xf       = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
      done_set = xf && ((n_xfer % NB) == NB - 1);
      dropped  = 0;
      if (xf) begin
         got_q.push_back({bus.out_last, bus.out_index, bus.out_data});
         n_xfer++;
      end
      if (bus.capture === 1'b1) begin
         if (occ < BANKS || done_set)
            model_accept(bus.neuron0_output, bus.neuron1_output, bus.neuron2_output, bus.neuron3_output);
         else
            dropped = 1;
      end
      if (done_set) occ--;
      if (bus.clr_ovf === 1'b1) m_ovf = 0;
      if (dropped) m_ovf = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      bus.capture   = 1'b0;
      while (!(got_q.size() >= exp_q.size() && bus.out_valid !== 1'b1) && n < budget) begin
         cycle();
         n++;
      end
   endtask

   task automatic test_reset();
      #3;
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b required 0", bus.out_valid); else pass_cnt++;
      chk_cnt++; if (bus.out_data !== 8'h00) $display("FAIL reset_data got %h required 00", bus.out_data); else pass_cnt++;
      chk_cnt++; if (bus.out_last !== 1'b0) $display("FAIL reset_last got %b required 0", bus.out_last); else pass_cnt++;
      chk_cnt++; if (bus.out_index !== 2'd3) $display("FAIL reset_index got %0d required 3", bus.out_index); else pass_cnt++;
      chk_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b required 0", bus.full); else pass_cnt++;
      chk_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b required 0", bus.overflow); else pass_cnt++;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      model_reset();
      cycle();
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_idle_valid got %b required 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_single_set();
      bus.out_ready = 1'b1;
      load(8'h11, 8'h22, 8'h33, 8'h44);
      bus.capture = 1'b1;
      cycle();
      bus.capture = 1'b0;
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_latency_early got valid=%b required 0", bus.out_valid); else pass_cnt++;
      cycle();
      chk_cnt++;
      if ({bus.out_valid, bus.out_index, bus.out_data} !== {1'b1, exp_q[0][9:0]})
         $display("FAIL single_first_byte got valid=%b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                  bus.out_valid, bus.out_index, bus.out_data, exp_q[0][9:8], exp_q[0][7:0]);
      else pass_cnt++;
      drain(40);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL single_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL single_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_idle got valid=%b required 0", bus.out_valid); else pass_cnt++;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int n;
      bus.out_ready = 1'b1;
      load(8'h11, 8'h22, 8'h33, 8'h44);
      bus.capture = 1'b1;
      cycle();
      bus.capture = 1'b0;
      n = 0;
      while (got_q.size() < 1 && n < 20) begin
         cycle();
         n++;
      end
      chk_cnt++; if (got_q.size() != 1) $display("FAIL bp_first_xfer got %0d bytes required 1", got_q.size()); else pass_cnt++;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_cnt++;
         if ({bus.out_valid, bus.out_index, bus.out_data} !== {1'b1, exp_q[1][9:0]})
            $display("FAIL bp_hold%0d got valid=%b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                     i, bus.out_valid, bus.out_index, bus.out_data, exp_q[1][9:8], exp_q[1][7:0]);
         else pass_cnt++;
      end
      drain(40);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL bp_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_overflow();
      bus.out_ready = 1'b0;
      for (int i = 0; i < BANKS + 1; i++) begin
         load_random();
         bus.capture = 1'b1;
         cycle();
      end
      bus.capture = 1'b0;
      cycle();
      chk_cnt++; if (bus.full !== (occ == BANKS)) $display("FAIL ovf_full got %b required %b", bus.full, occ == BANKS); else pass_cnt++;
      chk_cnt++; if (bus.overflow !== m_ovf) $display("FAIL ovf_set got %b required %b", bus.overflow, m_ovf); else pass_cnt++;
      bus.clr_ovf = 1'b1;
      cycle();
      bus.clr_ovf = 1'b0;
      chk_cnt++; if (bus.overflow !== m_ovf) $display("FAIL ovf_clear got %b required %b", bus.overflow, m_ovf); else pass_cnt++;
      load_random();
      bus.capture = 1'b1;
      bus.clr_ovf = 1'b1;
      cycle();
      bus.capture = 1'b0;
      bus.clr_ovf = 1'b0;
      chk_cnt++; if (bus.overflow !== m_ovf) $display("FAIL ovf_set_wins got %b required %b", bus.overflow, m_ovf); else pass_cnt++;
      bus.clr_ovf = 1'b1;
      cycle();
      bus.clr_ovf = 1'b0;
      drain(60);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL ovf_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL ovf_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (bus.full !== 1'b0) $display("FAIL ovf_drained_full got %b required 0", bus.full); else pass_cnt++;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_boundary();
      int n, idle;
      bus.out_ready = 1'b0;
      for (int i = 0; i < BANKS; i++) begin
         load_random();
         bus.capture = 1'b1;
         cycle();
      end
      bus.capture = 1'b0;
      chk_cnt++; if (bus.full !== 1'b1) $display("FAIL bnd_full got %b required 1", bus.full); else pass_cnt++;
      bus.out_ready = 1'b1;
      n = 0;
      while (!((n_xfer % NB) == NB - 1 && bus.out_valid === 1'b1) && n < 20) begin
         cycle();
         n++;
      end
      chk_cnt++; if (bus.out_last !== 1'b1) $display("FAIL bnd_at_last got out_last=%b required 1", bus.out_last); else pass_cnt++;
      load_random();
      bus.capture = 1'b1;
      cycle();
      bus.capture = 1'b0;
      chk_cnt++; if (bus.overflow !== m_ovf) $display("FAIL bnd_overflow got %b required %b", bus.overflow, m_ovf); else pass_cnt++;
      chk_cnt++; if (bus.full !== (occ == BANKS)) $display("FAIL bnd_full_after got %b required %b", bus.full, occ == BANKS); else pass_cnt++;
      idle = 0;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 60) begin
         if (bus.out_valid !== 1'b1) idle++;
         cycle();
         n++;
      end
      chk_cnt++; if (idle != 0) $display("FAIL bnd_no_bubble got %0d idle cycles required 0", idle); else pass_cnt++;
      drain(20);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL bnd_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bnd_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      logic       pv, pr;
      logic [9:0] pd;
      for (int c = 0; c < 400; c++) begin
         load_random();
         bus.capture   = ($urandom_range(0, 5) == 0);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.clr_ovf   = ($urandom_range(0, 29) == 0);
         pv = bus.out_valid;
         pr = bus.out_ready;
         pd = {bus.out_index, bus.out_data};
         cycle();
         chk_cnt++; if (bus.full !== (occ == BANKS)) $display("FAIL rnd_full c%0d got %b required %b", c, bus.full, occ == BANKS); else pass_cnt++;
         chk_cnt++; if (bus.overflow !== m_ovf) $display("FAIL rnd_overflow c%0d got %b required %b", c, bus.overflow, m_ovf); else pass_cnt++;
         if (pv === 1'b1 && pr === 1'b0) begin
            chk_cnt++;
            if ({bus.out_valid, bus.out_index, bus.out_data} !== {1'b1, pd})
               $display("FAIL rnd_hold c%0d got valid=%b %h required valid=1 %h", c, bus.out_valid, {bus.out_index, bus.out_data}, pd);
            else pass_cnt++;
         end
      end
      bus.clr_ovf = 1'b0;
      drain(80);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rnd_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_stream();
      int n;
      bus.out_ready = 1'b1;
      load_random();
      bus.capture = 1'b1;
      cycle();
      bus.capture = 1'b0;
      n = 0;
      while (got_q.size() < 2 && n < 20) begin
         cycle();
         n++;
      end
      chk_cnt++; if (got_q.size() != 2) $display("FAIL mid_two_bytes got %0d required 2", got_q.size()); else pass_cnt++;
      rstn = 1'b1;
      #1;
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_async_valid got %b required 0", bus.out_valid); else pass_cnt++;
      chk_cnt++; if (bus.out_index !== 2'd3) $display("FAIL mid_async_index got %0d required 3", bus.out_index); else pass_cnt++;
      model_reset();
      cycle();
      rstn = 1'b0;
      cycle();
      chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_empty_valid got %b required 0", bus.out_valid); else pass_cnt++;
      load_random();
      bus.capture = 1'b1;
      cycle();
      bus.capture = 1'b0;
      drain(40);
      chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL mid_len got %0d required %0d", got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q[i] !== exp_q[i]) $display("FAIL mid_byte%0d got %h required %h", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rstn          = 1'b1;
      bus.capture   = 1'b0;
      bus.clr_ovf   = 1'b0;
      bus.out_ready = 1'b0;
      load(8'h00, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_single_set();
      test_backpressure();
      test_overflow();
      test_boundary();
      test_random();
      test_reset_mid_stream();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
